// File: rtl/riscv_pkg.sv
// Shared core types and constants.
// Imported by every pipeline stage.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection for the fetch stage.
// Flags misaligned or out-of-range targets.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int IMEM_BYTES = 128
) (
    input  logic [XLEN-1:0] pc_q,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_d,
    output logic            fault_d
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - INSTR_BYTES);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

    always_comb begin
        pc_d    = pc_q;
        fault_d = 1'b0;
        unique case (1'b1)
            redirect_valid: begin
                pc_d    = redirect_target;
                fault_d = (redirect_target[1:0] != 2'b00)
                       || (redirect_target > LAST_PC);
            end
            (stall && !redirect_valid): begin
                pc_d = pc_q;
            end
            default: begin
                pc_d    = pc_q + STEP;
                fault_d = pc_q > LAST_PC;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect/stall FSM,
// and pairing of returned memory words with their PC.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic            clk,
    input  logic            resetn,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_instr,
    output logic            fetch_fault
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fault_d;
    logic            hold_q;
    logic [XLEN-1:0] hold_instr_q;

    pc_next_sel #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_sel (
        .pc_q           (pc_q),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc_d           (pc_d),
        .fault_d        (fault_d)
    );

    assign imem_addr = pc_q;

    // While stalled the memory is already reading the next PC, so the
    // word paired with fetch_pc is captured on the first stalled edge.
    assign fetch_instr = !fetch_valid ? NOP_INSTR
                       : hold_q       ? hold_instr_q
                       :                imem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q         <= RESET_PC;
            state_q      <= S_RUN;
            fetch_valid  <= 1'b0;
            fetch_pc     <= '0;
            fetch_fault  <= 1'b0;
            hold_q       <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            unique case (state_q)
                S_HALT: begin
                    fetch_valid <= 1'b0;
                    hold_q      <= 1'b0;
                end
                default: begin
                    if (fault_d) begin
                        state_q     <= S_HALT;
                        fetch_fault <= 1'b1;
                        fetch_valid <= 1'b0;
                        hold_q      <= 1'b0;
                    end else if (redirect_valid) begin
                        pc_q        <= pc_d;
                        fetch_valid <= 1'b0;
                        state_q     <= S_FLUSH;
                        hold_q      <= 1'b0;
                    end else if (stall) begin
                        if (fetch_valid && !hold_q) begin
                            hold_q       <= 1'b1;
                            hold_instr_q <= imem_rdata;
                        end
                    end else begin
                        fetch_valid <= 1'b1;
                        fetch_pc    <= pc_q;
                        pc_q        <= pc_d;
                        state_q     <= S_RUN;
                        hold_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a preloaded big-endian instruction memory
// and a per-cycle expectation queue.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(128)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h04:  return 32'h00F0_0093;
            32'h08:  return 32'h03A0_C113;
            32'h10:  return 32'h0011_22B3;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    logic [7:0] mem [0:127];

    initial begin
        for (int a = 0; a < 128; a += 4) begin
            logic [31:0] w;
            w = img(32'(a));
            mem[a]   = w[31:24];
            mem[a+1] = w[23:16];
            mem[a+2] = w[15:8];
            mem[a+3] = w[7:0];
        end
    end

    always @(posedge clk) begin
        if (!resetn)
            imem_rdata <= 32'h0;
        else if (imem_addr < 32'd125)
            imem_rdata <= {mem[imem_addr[6:0]],
                           mem[imem_addr[6:0] + 7'd1],
                           mem[imem_addr[6:0] + 7'd2],
                           mem[imem_addr[6:0] + 7'd3]};
        else
            imem_rdata <= 32'h0;
    end

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("valid", {31'b0, fetch_valid}, {31'b0, mon_e.v});
            check("fault", {31'b0, fetch_fault}, {31'b0, mon_e.f});
            if (mon_e.v) begin
                check("pc", fetch_pc, mon_e.pc);
                check("instr", fetch_instr, img(mon_e.pc));
            end else begin
                check("nop", fetch_instr, NOP);
            end
        end
    end

    task automatic cyc(input logic st, input logic rv,
                       input logic [31:0] rt, input logic ev,
                       input logic [31:0] epc, input logic ef);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        @(posedge clk);
        sb.push_back(exp_t'{ev, epc, ef});
        @(negedge clk);
        #1;
    endtask

    // Redirect to a misaligned target during reset: reset must win.
    task automatic do_reset(input logic st);
        resetn = 1'b0;
        cyc(st, 1'b1, 32'h0E, 1'b0, 32'h0, 1'b0);
        cyc(st, 1'b1, 32'h0E, 1'b0, 32'h0, 1'b0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn          = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        @(negedge clk);
        #1;
        do_reset(1'b0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // sequential fetch and a 3-cycle stall at pc 8
        cyc(0, 0, 0, 1, 32'h00, 0);
        cyc(0, 0, 0, 1, 32'h04, 0);
        cyc(0, 0, 0, 1, 32'h08, 0);
        cyc(1, 0, 0, 1, 32'h08, 0);
        cyc(1, 0, 0, 1, 32'h08, 0);
        cyc(1, 0, 0, 1, 32'h08, 0);
        cyc(0, 0, 0, 1, 32'h0C, 0);
        cyc(0, 0, 0, 1, 32'h10, 0);

        // redirect at pc 4
        do_reset(1'b0);
        cyc(0, 0, 0, 1, 32'h00, 0);
        cyc(0, 0, 0, 1, 32'h04, 0);
        cyc(0, 1, 32'h10, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h10, 0);
        cyc(0, 0, 0, 1, 32'h14, 0);

        // redirect beats stall, then stall inside the flush bubble
        cyc(1, 1, 32'h20, 0, 32'h0, 0);
        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h20, 0);

        // back-to-back redirects: last one wins
        cyc(0, 1, 32'h40, 0, 32'h0, 0);
        cyc(0, 1, 32'h08, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h08, 0);
        cyc(0, 0, 0, 1, 32'h0C, 0);

        // reset while stalled
        cyc(1, 0, 0, 1, 32'h0C, 0);
        do_reset(1'b1);
        cyc(0, 0, 0, 1, 32'h00, 0);

        // misaligned target halts; later inputs ignored
        cyc(0, 1, 32'h0E, 0, 32'h0, 1);
        cyc(0, 1, 32'h10, 0, 32'h0, 1);
        cyc(1, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 32'h0, 1);

        // aligned target beyond memory
        do_reset(1'b0);
        cyc(0, 0, 0, 1, 32'h00, 0);
        cyc(0, 1, 32'h80, 0, 32'h0, 1);

        // redirect to the last legal word, then run off the end
        do_reset(1'b0);
        cyc(0, 0, 0, 1, 32'h00, 0);
        cyc(0, 1, 32'h7C, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h7C, 0);
        cyc(0, 0, 0, 0, 32'h0, 1);

        // full sequential sweep past 0x7C
        do_reset(1'b0);
        for (int i = 0; i < 32; i++)
            cyc(0, 0, 0, 1, 32'(i * 4), 0);
        cyc(0, 0, 0, 0, 32'h0, 1);
        cyc(1, 1, 32'h10, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 32'h0, 1);

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
